// File: rtl/lift_fifo_if.sv
// Handshake and status bundle for lift_fifo: the writer/reader side is the
// master, the FIFO itself is the slave.
interface lift_fifo_if #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             enw;
    logic [WIDTH-1:0] datain;
    logic             enr;
    logic             clr_err;
    logic [WIDTH-1:0] dataout;
    logic             valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output enw, datain, enr, clr_err,
        input  dataout, valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  enw, datain, enr, clr_err,
        output dataout, valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/lift_fifo.sv
// Synchronous circular-buffer FIFO with registered read data, registered
// status flags and sticky overflow/underflow error flags.
module lift_fifo #(
    parameter int WIDTH     = 15,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input logic       clk,
    input logic       rst_n,
    lift_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             aempty_q, aempty_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc_s, rd_acc_s;

    // Accept decisions and next-state for pointers, count, read data and flags
    always_comb begin
        wr_acc_s = bus.enw & (~full_q | bus.enr);
        rd_acc_s = bus.enr & ~empty_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
            dout_d   = mem[rd_ptr_q];
            valid_d  = 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
            dout_d   = dout_q;
            valid_d  = 1'b0;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        // A fresh error in the same cycle as clr_err keeps the flag set
        if (bus.enw & ~wr_acc_s) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (bus.enr & empty_q) begin
            unf_d = 1'b1;
        end else if (bus.clr_err) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end

        empty_d  = (count_d == CW'(1'b0));
        full_d   = (count_d == CW'(DEPTH));
        aempty_d = (count_d <= CW'(AEMPTY_TH));
        afull_d  = (count_d >= CW'(AFULL_TH));
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            dout_q   <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; left unreset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_s) begin
            mem[wr_ptr_q] <= bus.datain;
        end else begin
            mem[wr_ptr_q] <= mem[wr_ptr_q];
        end
    end

    assign bus.dataout      = dout_q;
    assign bus.valid        = valid_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = aempty_q;
    assign bus.almost_full  = afull_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_lift_fifo.sv
// Scoreboard bench for lift_fifo: a default 16-deep instance for directed
// scenarios and an 8-deep instance for random bursts with wrap-around.
module tb_lift_fifo;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lift_fifo_if #(.WIDTH(15), .DEPTH(16)) bus_a();
    lift_fifo_if #(.WIDTH(15), .DEPTH(8))  bus_b();

    lift_fifo #(.WIDTH(15), .DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    lift_fifo #(.WIDTH(15), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference models: queue of stored words plus expected registered outputs
    logic [14:0] qa[$];
    logic [14:0] a_data;
    logic        a_valid, a_ovf, a_unf;
    logic [14:0] qb[$];
    logic [14:0] b_data;
    logic        b_valid, b_ovf, b_unf;

    function automatic logic [6:0] exp_a();
        return {qa.size() == 0, qa.size() == 16, qa.size() <= 2, qa.size() >= 14,
                a_valid, a_ovf, a_unf};
    endfunction

    function automatic logic [6:0] exp_b();
        return {qb.size() == 0, qb.size() == 8, qb.size() <= 1, qb.size() >= 6,
                b_valid, b_ovf, b_unf};
    endfunction

    task automatic cyc_a(input logic w, input logic [14:0] d, input logic r, input logic c);
        logic wacc, racc;
        bus_a.enw = w; bus_a.datain = d; bus_a.enr = r; bus_a.clr_err = c;
        wacc = w && (qa.size() < 16 || r);
        racc = r && (qa.size() > 0);
        if (racc) begin a_data = qa.pop_front(); a_valid = 1'b1; end
        else a_valid = 1'b0;
        if (wacc) qa.push_back(d);
        if (w && !wacc) a_ovf = 1'b1; else if (c) a_ovf = 1'b0;
        if (r && !racc) a_unf = 1'b1; else if (c) a_unf = 1'b0;
        @(posedge clk); #1;
        bus_a.enw = 1'b0; bus_a.enr = 1'b0; bus_a.clr_err = 1'b0;
    endtask

    task automatic cyc_b(input logic w, input logic [14:0] d, input logic r);
        logic wacc, racc;
        bus_b.enw = w; bus_b.datain = d; bus_b.enr = r; bus_b.clr_err = 1'b0;
        wacc = w && (qb.size() < 8 || r);
        racc = r && (qb.size() > 0);
        if (racc) begin b_data = qb.pop_front(); b_valid = 1'b1; end
        else b_valid = 1'b0;
        if (wacc) qb.push_back(d);
        if (w && !wacc) b_ovf = 1'b1;
        if (r && !racc) b_unf = 1'b1;
        @(posedge clk); #1;
        bus_b.enw = 1'b0; bus_b.enr = 1'b0;
    endtask

    task automatic do_reset(input logic w, input logic r, input logic c);
        bus_a.enw = w; bus_a.enr = r; bus_a.clr_err = c; bus_a.datain = 15'h5555;
        bus_b.enw = w; bus_b.enr = r; bus_b.clr_err = c; bus_b.datain = 15'h5555;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_a.enw = 1'b0; bus_a.enr = 1'b0; bus_a.clr_err = 1'b0;
        bus_b.enw = 1'b0; bus_b.enr = 1'b0; bus_b.clr_err = 1'b0;
        qa.delete(); a_data = 15'h0; a_valid = 1'b0; a_ovf = 1'b0; a_unf = 1'b0;
        qb.delete(); b_data = 15'h0; b_valid = 1'b0; b_ovf = 1'b0; b_unf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({bus_a.empty, bus_a.full, bus_a.almost_empty, bus_a.almost_full,
             bus_a.valid, bus_a.overflow, bus_a.underflow} !== 7'b1010000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", {bus_a.empty, bus_a.full,
                     bus_a.almost_empty, bus_a.almost_full, bus_a.valid,
                     bus_a.overflow, bus_a.underflow}, 7'b1010000);
        end
        n_tests++;
        if (bus_a.count !== 5'd0 || bus_a.dataout !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_count_data: got %0d/%h want 0/0000", bus_a.count, bus_a.dataout);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            cyc_a(1'b1, 15'(i), 1'b0, 1'b0);
            n_tests++;
            if (bus_a.count !== 5'(qa.size()) || {bus_a.empty, bus_a.full, bus_a.almost_empty,
                bus_a.almost_full, bus_a.valid, bus_a.overflow, bus_a.underflow} !== exp_a()) begin
                n_fail++;
                $display("FAIL fill_status[%0d]: got count %0d flags %b want %0d %b", i,
                         bus_a.count, {bus_a.empty, bus_a.full, bus_a.almost_empty,
                         bus_a.almost_full, bus_a.valid, bus_a.overflow, bus_a.underflow},
                         qa.size(), exp_a());
            end
        end
        n_tests++;
        if (bus_a.full !== 1'b1 || bus_a.count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_full: got full %b count %0d want 1 16", bus_a.full, bus_a.count);
        end
        for (int i = 1; i <= 16; i++) begin
            cyc_a(1'b0, 15'h0, 1'b1, 1'b0);
            n_tests++;
            if (bus_a.valid !== 1'b1 || bus_a.dataout !== a_data || bus_a.dataout !== 15'(i)) begin
                n_fail++;
                $display("FAIL drain_data[%0d]: got %b/%h want 1/%h", i, bus_a.valid, bus_a.dataout, 15'(i));
            end
            n_tests++;
            if ({bus_a.empty, bus_a.full, bus_a.almost_empty, bus_a.almost_full} !== exp_a()[6:3]) begin
                n_fail++;
                $display("FAIL drain_flags[%0d]: got %b want %b", i, {bus_a.empty, bus_a.full,
                         bus_a.almost_empty, bus_a.almost_full}, exp_a()[6:3]);
            end
        end
        cyc_a(1'b0, 15'h0, 1'b0, 1'b0);
        n_tests++;
        if (bus_a.empty !== 1'b1 || bus_a.valid !== 1'b0 || bus_a.dataout !== 15'h0010) begin
            n_fail++;
            $display("FAIL drain_end: got empty %b valid %b data %h want 1 0 0010",
                     bus_a.empty, bus_a.valid, bus_a.dataout);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) cyc_a(1'b1, 15'h100 + 15'(i), 1'b0, 1'b0);
        cyc_a(1'b1, 15'h7FFF, 1'b0, 1'b0);
        n_tests++;
        if (bus_a.count !== 5'd16 || bus_a.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got count %0d ovf %b want 16 1", bus_a.count, bus_a.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            cyc_a(1'b0, 15'h0, 1'b1, 1'b0);
            n_tests++;
            if (bus_a.dataout === 15'h7FFF || bus_a.dataout !== a_data || bus_a.valid !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got %h want %h", i, bus_a.dataout, a_data);
            end
        end
        cyc_a(1'b0, 15'h0, 1'b0, 1'b1);
        n_tests++;
        if (bus_a.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", bus_a.overflow);
        end
    endtask

    task automatic test_underflow();
        cyc_a(1'b1, 15'h1234, 1'b1, 1'b0);
        n_tests++;
        if (bus_a.underflow !== 1'b1 || bus_a.valid !== 1'b0 || bus_a.count !== 5'd1) begin
            n_fail++;
            $display("FAIL unf_set: got unf %b valid %b count %0d want 1 0 1",
                     bus_a.underflow, bus_a.valid, bus_a.count);
        end
        cyc_a(1'b0, 15'h0, 1'b1, 1'b0);
        n_tests++;
        if (bus_a.dataout !== 15'h1234 || bus_a.valid !== 1'b1 || bus_a.dataout !== a_data) begin
            n_fail++;
            $display("FAIL unf_read: got %b/%h want 1/1234", bus_a.valid, bus_a.dataout);
        end
        cyc_a(1'b0, 15'h0, 1'b0, 1'b1);
        n_tests++;
        if (bus_a.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL unf_clear: got %b want 0", bus_a.underflow);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) cyc_a(1'b1, 15'h200 + 15'(i), 1'b0, 1'b0);
        cyc_a(1'b1, 15'h0AAA, 1'b1, 1'b0);
        n_tests++;
        if (bus_a.count !== 5'd16 || bus_a.overflow !== 1'b0 || bus_a.valid !== 1'b1 ||
            bus_a.dataout !== 15'h200) begin
            n_fail++;
            $display("FAIL full_rw: got count %0d ovf %b valid %b data %h want 16 0 1 0200",
                     bus_a.count, bus_a.overflow, bus_a.valid, bus_a.dataout);
        end
        for (int i = 1; i <= 16; i++) begin
            cyc_a(1'b0, 15'h0, 1'b1, 1'b0);
            n_tests++;
            if (bus_a.dataout !== ((i == 16) ? 15'h0AAA : 15'h200 + 15'(i)) || bus_a.dataout !== a_data) begin
                n_fail++;
                $display("FAIL full_rw_order[%0d]: got %h want %h", i, bus_a.dataout,
                         (i == 16) ? 15'h0AAA : 15'h200 + 15'(i));
            end
        end
    endtask

    task automatic test_clr_priority();
        for (int i = 0; i < 16; i++) cyc_a(1'b1, 15'h300 + 15'(i), 1'b0, 1'b0);
        cyc_a(1'b1, 15'h7777, 1'b0, 1'b1);
        n_tests++;
        if (bus_a.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_ovf: got %b want 1", bus_a.overflow);
        end
        for (int i = 0; i < 16; i++) cyc_a(1'b0, 15'h0, 1'b1, 1'b0);
        cyc_a(1'b0, 15'h0, 1'b1, 1'b1);
        n_tests++;
        if (bus_a.underflow !== 1'b1 || bus_a.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_vs_unf: got unf %b ovf %b want 1 0", bus_a.underflow, bus_a.overflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 15'h400 + 15'(i), 1'b0, 1'b0);
        cyc_a(1'b0, 15'h0, 1'b1, 1'b0);
        do_reset(1'b1, 1'b1, 1'b1);
        n_tests++;
        if ({bus_a.empty, bus_a.full, bus_a.almost_empty, bus_a.almost_full, bus_a.valid,
             bus_a.overflow, bus_a.underflow} !== 7'b1010000 || bus_a.count !== 5'd0 ||
            bus_a.dataout !== 15'h0) begin
            n_fail++;
            $display("FAIL midreset_state: got flags %b count %0d data %h want 1010000 0 0000",
                     {bus_a.empty, bus_a.full, bus_a.almost_empty, bus_a.almost_full,
                      bus_a.valid, bus_a.overflow, bus_a.underflow}, bus_a.count, bus_a.dataout);
        end
        cyc_a(1'b1, 15'h0042, 1'b0, 1'b0);
        cyc_a(1'b0, 15'h0, 1'b1, 1'b0);
        n_tests++;
        if (bus_a.valid !== 1'b1 || bus_a.dataout !== 15'h0042) begin
            n_fail++;
            $display("FAIL midreset_read: got %b/%h want 1/0042", bus_a.valid, bus_a.dataout);
        end
    endtask

    task automatic check_b(input string tag);
        n_tests++;
        if (bus_b.count !== 4'(qb.size()) || bus_b.count > 4'd8 ||
            {bus_b.empty, bus_b.full, bus_b.almost_empty, bus_b.almost_full, bus_b.valid,
             bus_b.overflow, bus_b.underflow} !== exp_b() || bus_b.dataout !== b_data) begin
            n_fail++;
            $display("FAIL %s: got count %0d flags %b data %h want %0d %b %h", tag, bus_b.count,
                     {bus_b.empty, bus_b.full, bus_b.almost_empty, bus_b.almost_full,
                      bus_b.valid, bus_b.overflow, bus_b.underflow}, bus_b.dataout,
                     qb.size(), exp_b(), b_data);
        end
    endtask

    task automatic test_wrap();
        logic w, r;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) begin
                cyc_b(1'b1, 15'(k * 8 + i + 1), 1'b0);
                check_b("wrap_fill");
            end
            for (int i = 0; i < 8; i++) begin
                cyc_b(1'b0, 15'h0, 1'b1);
                check_b("wrap_drain");
            end
        end
        for (int b = 0; b < 40; b++) begin
            int len;
            len = $urandom_range(2, 10);
            for (int i = 0; i < len; i++) begin
                if (b % 2 == 0) begin
                    w = ($urandom_range(0, 9) < 9);
                    r = ($urandom_range(0, 9) < 3);
                end else begin
                    w = ($urandom_range(0, 9) < 3);
                    r = ($urandom_range(0, 9) < 9);
                end
                cyc_b(w, 15'($urandom_range(0, 32767)), r);
                check_b("burst");
            end
        end
    endtask

    initial begin
        bus_a.enw = 1'b0; bus_a.enr = 1'b0; bus_a.clr_err = 1'b0; bus_a.datain = 15'h0;
        bus_b.enw = 1'b0; bus_b.enr = 1'b0; bus_b.clr_err = 1'b0; bus_b.datain = 15'h0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_full_rw();
        test_clr_priority();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lift_fifo.md
LIFT_FIFO -- requirements
Module: lift_fifo

Interface
REQ-001 Parameter WIDTH, default 15: data word width in bits, from 1 to 32.
REQ-002 Parameter DEPTH, default 16: storage depth in words; a power of two, 2 to 1024.
REQ-003 Parameter AFULL_TH, default DEPTH-2: almost_full asserts when count >= AFULL_TH.
REQ-004 Parameter AEMPTY_TH, default 2: almost_empty asserts when count <= AEMPTY_TH.
REQ-005 clk  in  1: the single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1: synchronous reset, active-low, sampled on the clk rising edge.
REQ-007 enw  in  1: write request; datain is captured when the write is accepted.
REQ-008 datain  in  WIDTH: write data.
REQ-009 enr  in  1: read request.
REQ-010 dataout  out  WIDTH: registered read data.
REQ-011 valid  out  1: one-cycle pulse; dataout carries a newly read word.
REQ-012 empty  out  1: count == 0.
REQ-013 full  out  1: count == DEPTH.
REQ-014 almost_empty  out  1: count <= AEMPTY_TH.
REQ-015 almost_full  out  1: count >= AFULL_TH.
REQ-016 count  out  log2(DEPTH)+1: number of words stored.
REQ-017 overflow  out  1: sticky flag; a write was dropped.
REQ-018 underflow  out  1: sticky flag; a read was rejected.
REQ-019 clr_err  in  1: synchronous clear of overflow and underflow.

Function
REQ-020 Storage SHALL be a DEPTH-entry circular buffer with write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-021 A write SHALL be accepted when enw=1 and either full=0, or full=1 with enr=1 in the same cycle.
REQ-022 A read SHALL be accepted when enr=1 and empty=0.
REQ-023 An accepted read SHALL load mem[rd_ptr] into dataout and assert valid on the same clk edge, giving one-cycle latency from enr.
REQ-024 dataout SHALL hold its last value when no read is accepted; valid SHALL then be 0.
REQ-025 A write of datain and a read in the same cycle SHALL NOT produce a same-cycle bypass to dataout: when the FIFO is empty, the written word is readable from the next cycle.
REQ-026 count SHALL be updated as follows:
  - +1 on a write-only cycle;
  - -1 on a read-only cycle;
  - unchanged when both a write and a read are accepted;
  - never outside the range 0..DEPTH.
REQ-027 enw=1 while full=1 and enr=0 SHALL drop the word, leave pointers and count unchanged, and set overflow.
REQ-028 enr=1 while empty=1 SHALL leave state unchanged, set underflow and keep valid=0; a simultaneous enw SHALL still be accepted.
REQ-029 All status flags SHALL be registered outputs consistent with the registered count in the same cycle; there SHALL be no combinational path from enw or enr to any output.
REQ-030 clr_err=1 SHALL clear overflow and underflow on the next edge, except that a new error in that same cycle SHALL win and the flag SHALL remain set.
REQ-031 The circuit SHALL be synthesisable with mem inferred as RAM or registers; mem contents SHALL NOT be reset.

Reset
REQ-032 While rst_n=0 at a clk edge, the following SHALL be set, overriding enw, enr and clr_err:
  - pointers = 0, count = 0;
  - empty = 1, full = 0;
  - almost_empty = 1, almost_full = 0;
  - valid = 0, dataout = 0;
  - overflow = 0, underflow = 0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words; the first read after reset SHALL return the first word written after reset.

Verification
REQ-034 Fill and drain, defaults: write 0x0001..0x0010 (16 words) -> full=1 and count=16 after the 16th edge; then 16 reads -> dataout equals 0x0001..0x0010 in order, each one edge after enr, and empty=1 at the end.
REQ-035 Overflow: with the FIFO full, write 0x7FFF with enr=0 -> count stays 16 and overflow=1; the following drain contains no 0x7FFF; clr_err=1 for one cycle -> overflow=0.
REQ-036 Underflow with concurrent write: with the FIFO empty, enr=1, enw=1, datain=0x1234 -> underflow=1, valid=0, count=1; next cycle enr=1 -> dataout=0x1234, valid=1.
REQ-037 Full with simultaneous read and write: with the FIFO full, enr=1, enw=1, datain=0x0AAA -> count stays 16 and no overflow; 0x0AAA is read back as the 16th word after the current head.
REQ-038 Thresholds and wrap-around: run 40 random-length bursts with DEPTH=8, AFULL_TH=6, AEMPTY_TH=1 -> flags match a scoreboard every cycle, data order is preserved across at least 4 pointer wraps, and count never leaves 0..8.
REQ-039 Reset mid-stream: hold 5 words, drive rst_n=0 for one edge -> all outputs at their REQ-032 values; write 0x0042 then read -> dataout=0x0042.
